// File: rtl/systola_arr_seq_if.sv
// Host load handshake, single-port SRAM port and operand stream of the Systola sequencer.
interface systola_arr_seq_if #(
   parameter int WORD_LEN = 8,
   parameter int ADDR_W   = 15
);
   logic [1:0]          mode;
   logic                fire;
   logic                in_valid;
   logic                in_ready;
   logic [WORD_LEN-1:0] in_data;
   logic                mem_cen;
   logic                mem_wen;
   logic [ADDR_W-1:0]   mem_addr;
   logic [WORD_LEN-1:0] mem_d;
   logic [WORD_LEN-1:0] mem_q;
   logic                arr_valid;
   logic                arr_first;
   logic                arr_last;
   logic [WORD_LEN-1:0] arr_data;
   logic                busy;
   logic                done;
   logic                err;

   modport slave (
      input  mode, fire, in_valid, in_data, mem_q,
      output in_ready, mem_cen, mem_wen, mem_addr, mem_d,
      output arr_valid, arr_first, arr_last, arr_data, busy, done, err
   );

   modport master (
      output mode, fire, in_valid, in_data, mem_q,
      input  in_ready, mem_cen, mem_wen, mem_addr, mem_d,
      input  arr_valid, arr_first, arr_last, arr_data, busy, done, err
   );
endinterface

// File: rtl/systola_arr_seq.sv
// Systola array sequencer: loads config/feature data into SRAM, then streams 3x3 window operands.
// Optional dimension check on compute fire: define SYSTOLA_SEQ_CFG_CHECK_EN.
module systola_arr_seq #(
   parameter int WORD_LEN = 8,
   parameter int ADDR_W   = 15,
   parameter int DIM_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   systola_arr_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   ptr;
   logic                full;
   logic [DIM_W-1:0]    cfg [4];
   logic [DIM_W-1:0]    c_cnt, oy_cnt, ox_cnt;
   logic [1:0]          ky_cnt, kx_cnt;
   logic [ADDR_W-1:0]   line_base, win_base, row_base;
   logic                mem_cen, mem_wen;
   logic [ADDR_W-1:0]   mem_addr;
   logic [WORD_LEN-1:0] mem_d;
   logic                arr_valid, arr_first, arr_last;
   logic                busy, done, err;

   logic                load_mode, in_ready, xfer;
   logic                tap_first, tap_last, run_final, cfg_bad;
   logic [ADDR_W-1:0]   wptr, w_a, w3_a;

`ifdef SYSTOLA_SEQ_CFG_CHECK_EN
   localparam int VOL_W = 3 * DIM_W;
   localparam int VW1   = VOL_W + 1;
   localparam logic [VOL_W:0] DEPTH_V = VW1'(2 ** ADDR_W);
   logic [VOL_W-1:0] vol;
`endif

   // Host handshake, window-position decode and configuration sanity check.
   always_comb begin
      load_mode = (state == IDLE) && ((bus.mode == 2'b00) || (bus.mode == 2'b01));
      // Gated by rst so the handshake reads 0 while reset is held, whatever the mode.
      in_ready  = load_mode && !full && !rst;
      xfer      = bus.in_valid && in_ready;
      wptr      = (bus.fire && load_mode) ? {ADDR_W{1'b0}} : ptr;
      w_a       = ADDR_W'(cfg[2]);
      w3_a      = w_a + (w_a << 1);
      tap_first = (ky_cnt == 2'd0) && (kx_cnt == 2'd0);
      tap_last  = (ky_cnt == 2'd2) && (kx_cnt == 2'd2);
      run_final = tap_last && (ox_cnt == cfg[2] - DIM_W'(3)) &&
                  (oy_cnt == cfg[3] - DIM_W'(3)) && (c_cnt == cfg[1] - DIM_W'(1));
`ifdef SYSTOLA_SEQ_CFG_CHECK_EN
      vol     = VOL_W'(cfg[1]) * VOL_W'(cfg[2]) * VOL_W'(cfg[3]);
      cfg_bad = (cfg[2] < DIM_W'(3)) || (cfg[3] < DIM_W'(3)) ||
                (cfg[1] == {DIM_W{1'b0}}) || ({1'b0, vol} > DEPTH_V);
`else
      cfg_bad = 1'b0;
`endif
   end

   // Sequencer FSM, load pointer, SRAM port and delayed operand tags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= {ADDR_W{1'b0}};
         full      <= 1'b0;
         for (int i = 0; i < 4; i++) cfg[i] <= {DIM_W{1'b0}};
         c_cnt     <= {DIM_W{1'b0}};
         oy_cnt    <= {DIM_W{1'b0}};
         ox_cnt    <= {DIM_W{1'b0}};
         ky_cnt    <= 2'd0;
         kx_cnt    <= 2'd0;
         line_base <= {ADDR_W{1'b0}};
         win_base  <= {ADDR_W{1'b0}};
         row_base  <= {ADDR_W{1'b0}};
         mem_cen   <= 1'b1;
         mem_wen   <= 1'b1;
         mem_addr  <= {ADDR_W{1'b0}};
         mem_d     <= {WORD_LEN{1'b0}};
         arr_valid <= 1'b0;
         arr_first <= 1'b0;
         arr_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         arr_valid <= (state == RUN);
         arr_first <= (state == RUN) && tap_first;
         arr_last  <= (state == RUN) && tap_last;
         done      <= (state == RUN) && run_final && (bus.mode != 2'b11);
         case (state)
            IDLE: begin
               mem_cen <= 1'b1;
               mem_wen <= 1'b1;
               if (bus.fire && (bus.mode == 2'b10)) begin
                  err <= cfg_bad;
                  if (!cfg_bad) begin
                     state     <= RUN;
                     busy      <= 1'b1;
                     mem_cen   <= 1'b0;
                     mem_addr  <= {ADDR_W{1'b0}};
                     c_cnt     <= {DIM_W{1'b0}};
                     oy_cnt    <= {DIM_W{1'b0}};
                     ox_cnt    <= {DIM_W{1'b0}};
                     ky_cnt    <= 2'd0;
                     kx_cnt    <= 2'd0;
                     line_base <= {ADDR_W{1'b0}};
                     win_base  <= {ADDR_W{1'b0}};
                     row_base  <= {ADDR_W{1'b0}};
                  end
               end else begin
                  if (bus.fire) err <= 1'b0;
                  if (bus.fire && load_mode) begin
                     ptr  <= {ADDR_W{1'b0}};
                     full <= 1'b0;
                  end
                  if (xfer) begin
                     if (bus.mode == 2'b00) begin
                        cfg[wptr[1:0]] <= DIM_W'(bus.in_data);
                        ptr            <= ADDR_W'(wptr[1:0] + 2'd1);
                     end else begin
                        mem_cen  <= 1'b0;
                        mem_wen  <= 1'b0;
                        mem_addr <= wptr;
                        mem_d    <= bus.in_data;
                        ptr      <= wptr + ADDR_W'(1);
                        if (&wptr) full <= 1'b1;
                     end
                  end
               end
            end
            RUN: begin
               if (bus.mode == 2'b11) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  mem_cen <= 1'b1;
               end else if (run_final) begin
                  state   <= DRAIN;
                  mem_cen <= 1'b1;
               end else if (kx_cnt != 2'd2) begin
                  kx_cnt   <= kx_cnt + 2'd1;
                  mem_addr <= mem_addr + ADDR_W'(1);
               end else if (ky_cnt != 2'd2) begin
                  kx_cnt   <= 2'd0;
                  ky_cnt   <= ky_cnt + 2'd1;
                  row_base <= row_base + w_a;
                  mem_addr <= row_base + w_a;
               end else begin
                  kx_cnt <= 2'd0;
                  ky_cnt <= 2'd0;
                  // Each base is the start of the next window; channel start = last line + 3 rows.
                  if (ox_cnt != cfg[2] - DIM_W'(3)) begin
                     ox_cnt   <= ox_cnt + DIM_W'(1);
                     win_base <= win_base + ADDR_W'(1);
                     row_base <= win_base + ADDR_W'(1);
                     mem_addr <= win_base + ADDR_W'(1);
                  end else if (oy_cnt != cfg[3] - DIM_W'(3)) begin
                     ox_cnt    <= {DIM_W{1'b0}};
                     oy_cnt    <= oy_cnt + DIM_W'(1);
                     line_base <= line_base + w_a;
                     win_base  <= line_base + w_a;
                     row_base  <= line_base + w_a;
                     mem_addr  <= line_base + w_a;
                  end else begin
                     ox_cnt    <= {DIM_W{1'b0}};
                     oy_cnt    <= {DIM_W{1'b0}};
                     c_cnt     <= c_cnt + DIM_W'(1);
                     line_base <= line_base + w3_a;
                     win_base  <= line_base + w3_a;
                     row_base  <= line_base + w3_a;
                     mem_addr  <= line_base + w3_a;
                  end
               end
            end
            DRAIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               mem_cen <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.mem_cen   = mem_cen;
   assign bus.mem_wen   = mem_wen;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_d     = mem_d;
   assign bus.arr_valid = arr_valid;
   assign bus.arr_first = arr_first;
   assign bus.arr_last  = arr_last;
   assign bus.arr_data  = bus.mem_q;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.err       = err;
endmodule
